// File: rtl/dcache_coherence_agent.sv
// Cache-side coherence agent: miss writeback/fill initiator and snoop responder.
// Optional saturating stats counters: define DCACHE_AGENT_STATS_EN.
module dcache_coherence_agent #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              miss_excl,
    input  logic              vic_dirty,
    input  logic [ADDR_W-1:0] vic_addr,
    input  logic [DATA_W-1:0] vic_data0,
    input  logic [DATA_W-1:0] vic_data1,
    output logic [DATA_W-1:0] fill_data0,
    output logic [DATA_W-1:0] fill_data1,
    output logic              fill_done,
    output logic              dREN,
    output logic              dWEN,
    output logic [ADDR_W-1:0] daddr,
    output logic [DATA_W-1:0] dstore,
    input  logic [DATA_W-1:0] dload,
    input  logic              dwait,
    output logic              cctrans,
    output logic              ccwrite,
    input  logic              ccwait,
    input  logic              ccinv,
    input  logic [ADDR_W-1:0] ccsnoopaddr,
    output logic [ADDR_W-1:0] snp_addr,
    input  logic              snp_hit,
    input  logic              snp_mod,
    input  logic [DATA_W-1:0] snp_data0,
    input  logic [DATA_W-1:0] snp_data1,
    output logic              snp_inval,
    output logic              snp_dngrd
`ifdef DCACHE_AGENT_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_fills,
    output logic [CNT_W-1:0]  stat_wbs,
    output logic [CNT_W-1:0]  stat_snphits
`endif
);

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, REQ, RD0, RD1, DONE,
        SNP, SWB0, SWB1, SFIN
    } state_t;

    state_t            state;
    state_t            next;
    logic [DATA_W-1:0] word0;
    logic [DATA_W-1:0] word1;
    logic              cap0;
    logic              cap1;
    logic [ADDR_W-1:0] snp_blk;

    function automatic logic [ADDR_W-1:0] w0f(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:3], 3'b000};
    endfunction

    function automatic logic [ADDR_W-1:0] w1f(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:3], 3'b100};
    endfunction

    assign snp_blk    = w0f(ccsnoopaddr);
    assign fill_data0 = word0;
    assign fill_data1 = word1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            word0 <= '0;
            word1 <= '0;
        end else begin
            state <= next;
            if (cap0) word0 <= dload;
            if (cap1) word1 <= dload;
        end
    end

    always_comb begin
        next      = state;
        cap0      = 1'b0;
        cap1      = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = '0;
        dstore    = '0;
        cctrans   = 1'b0;
        ccwrite   = 1'b0;
        snp_addr  = '0;
        snp_inval = 1'b0;
        snp_dngrd = 1'b0;
        fill_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (ccwait)
                    next = SNP;
                else if (miss_req && vic_dirty)
                    next = WB0;
                else if (miss_req)
                    next = REQ;
            end
            WB0: begin
                dWEN   = 1'b1;
                daddr  = w0f(vic_addr);
                dstore = vic_data0;
                if (!dwait) next = WB1;
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = w1f(vic_addr);
                dstore = vic_data1;
                if (!dwait) next = REQ;
            end
            REQ: begin
                // A snoop arriving here wins; the request is reissued after SFIN.
                if (ccwait) begin
                    next = SNP;
                end else begin
                    cctrans = 1'b1;
                    ccwrite = miss_excl;
                    dREN    = 1'b1;
                    daddr   = w0f(miss_addr);
                    if (!dwait) begin
                        cap0 = 1'b1;
                        next = RD1;
                    end else begin
                        next = RD0;
                    end
                end
            end
            RD0: begin
                dREN  = 1'b1;
                daddr = w0f(miss_addr);
                if (!dwait) begin
                    cap0 = 1'b1;
                    next = RD1;
                end
            end
            RD1: begin
                dREN  = 1'b1;
                daddr = w1f(miss_addr);
                if (!dwait) begin
                    cap1 = 1'b1;
                    next = DONE;
                end
            end
            DONE: begin
                fill_done = 1'b1;
                next      = IDLE;
            end
            SNP: begin
                cctrans  = 1'b1;
                ccwrite  = snp_hit & snp_mod;
                snp_addr = snp_blk;
                if (!ccwait)
                    next = SFIN;
                else if (snp_hit && snp_mod)
                    next = SWB0;
                else
                    next = SFIN;
            end
            SWB0: begin
                cctrans  = 1'b1;
                ccwrite  = 1'b1;
                snp_addr = snp_blk;
                dstore   = snp_data0;
                if (!dwait) next = ccwait ? SWB1 : SFIN;
            end
            SWB1: begin
                cctrans  = 1'b1;
                ccwrite  = 1'b1;
                snp_addr = snp_blk;
                dstore   = snp_data1;
                if (!dwait) next = SFIN;
            end
            SFIN: begin
                snp_addr  = snp_blk;
                snp_inval = ccinv & snp_hit;
                snp_dngrd = ~ccinv & snp_hit & snp_mod;
                next      = miss_req ? REQ : IDLE;
            end
            default: next = IDLE;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{miss_addr[2:0], vic_addr[2:0], ccsnoopaddr[2:0]};

`ifdef DCACHE_AGENT_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_fills   <= '0;
            stat_wbs     <= '0;
            stat_snphits <= '0;
        end else begin
            if (state == DONE && stat_fills != '1)
                stat_fills <= stat_fills + 1'b1;
            if (state == WB1 && !dwait && stat_wbs != '1)
                stat_wbs <= stat_wbs + 1'b1;
            if (state == SFIN && snp_hit && stat_snphits != '1)
                stat_snphits <= stat_snphits + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_coherence_agent.sv
// Bench for dcache_coherence_agent: directed and randomized misses and snoops
// checked against transaction-level expectations from a memory/tag model.
module tb_dcache_coherence_agent;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          miss_req, miss_excl, vic_dirty;
    logic [AW-1:0] miss_addr, vic_addr;
    logic [DW-1:0] vic_data0, vic_data1;
    logic [DW-1:0] fill_data0, fill_data1;
    logic          fill_done, dREN, dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore, dload;
    logic          dwait, cctrans, ccwrite, ccwait, ccinv;
    logic [AW-1:0] ccsnoopaddr, snp_addr;
    logic          snp_hit, snp_mod;
    logic [DW-1:0] snp_data0, snp_data1;
    logic          snp_inval, snp_dngrd;
`ifdef DCACHE_AGENT_STATS_EN
    logic [CW-1:0] stat_fills, stat_wbs, stat_snphits;
`endif

    logic [DW-1:0] ld0, ld1;
    logic [AW-1:0] tag_addr;
    logic          tag_valid, tag_mod;
    logic [DW-1:0] tag_d0, tag_d1;
    logic [3*DW+2*AW+6:0] all_outs;

    int checks = 0;
    int errors = 0;
    int exp_fills = 0;
    int exp_wbs = 0;
    int exp_snphits = 0;

    dcache_coherence_agent #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .miss_excl(miss_excl), .vic_dirty(vic_dirty),
        .vic_addr(vic_addr), .vic_data0(vic_data0),
        .vic_data1(vic_data1), .fill_data0(fill_data0),
        .fill_data1(fill_data1), .fill_done(fill_done),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .dload(dload), .dwait(dwait),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .snp_addr(snp_addr),
        .snp_hit(snp_hit), .snp_mod(snp_mod),
        .snp_data0(snp_data0), .snp_data1(snp_data1),
        .snp_inval(snp_inval), .snp_dngrd(snp_dngrd)
`ifdef DCACHE_AGENT_STATS_EN
        ,
        .stat_fills(stat_fills), .stat_wbs(stat_wbs),
        .stat_snphits(stat_snphits)
`endif
    );

    always #5 CLK = ~CLK;

    always_comb dload = daddr[2] ? ld1 : ld0;

    always_comb begin
        snp_hit   = tag_valid && (snp_addr == tag_addr);
        snp_mod   = snp_hit && tag_mod;
        snp_data0 = tag_d0;
        snp_data1 = tag_d1;
    end

    always_comb all_outs = {fill_data0, fill_data1, fill_done, dREN, dWEN,
                            daddr, dstore, cctrans, ccwrite, snp_addr,
                            snp_inval, snp_dngrd};

    function automatic logic [AW-1:0] blk(input logic [AW-1:0] a);
        return {a[AW-1:3], 3'b000};
    endfunction

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic idle_inputs;
        miss_req = 0; miss_addr = '0; miss_excl = 0; vic_dirty = 0;
        vic_addr = '0; vic_data0 = '0; vic_data1 = '0;
        dwait = 0; ccwait = 0; ccinv = 0; ccsnoopaddr = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        ld0 = '0; ld1 = '0;
        tag_addr = '0; tag_valid = 0; tag_mod = 0;
        tag_d0 = '0; tag_d1 = '0;
        RST = 1;
        tick(); tick();
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_hold: outs=%h want 0", all_outs);
        end
        RST = 0;
        exp_fills = 0; exp_wbs = 0; exp_snphits = 0;
        tick();
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_idle: outs=%h want 0", all_outs);
        end
    endtask

    task automatic do_miss(input logic [AW-1:0] a, input logic excl,
                           input logic dirty, input logic [AW-1:0] va,
                           input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                           input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                           input int stall_pct, input string name);
        logic [AW-1:0] wq_a[$];
        logic [DW-1:0] wq_d[$];
        logic [AW-1:0] rq[$];
        logic [DW-1:0] got0, got1;
        logic [AW-1:0] w0, w1;
        int ctr, done_cyc, nwb;
        bit bad_both, bad_tr, bad_order;
        w0 = blk(a);
        w1 = {a[AW-1:3], 3'b100};
        nwb = dirty ? 2 : 0;
        ctr = 0; done_cyc = -1;
        bad_both = 0; bad_tr = 0; bad_order = 0;
        got0 = '0; got1 = '0;
        ld0 = l0; ld1 = l1;
        tick();
        miss_req = 1; miss_addr = a; miss_excl = excl;
        vic_dirty = dirty; vic_addr = va;
        vic_data0 = v0; vic_data1 = v1; dwait = 0;
        for (int c = 0; c < 200 && done_cyc < 0; c++) begin
            if (c > 0) begin
                tick();
                dwait = ($urandom_range(99) < stall_pct);
            end
            #1;
            if (dREN && dWEN) bad_both = 1;
            if (cctrans) begin
                ctr++;
                if (!dREN || rq.size() != 0 || wq_a.size() != nwb ||
                    ccwrite !== excl || daddr !== w0)
                    bad_tr = 1;
            end
            if (dWEN && !dwait) begin
                wq_a.push_back(daddr);
                wq_d.push_back(dstore);
            end
            if (dREN && !dwait) begin
                if (wq_a.size() != nwb) bad_order = 1;
                rq.push_back(daddr);
            end
            if (fill_done) begin
                done_cyc = c;
                got0 = fill_data0;
                got1 = fill_data1;
                miss_req = 0;
            end
        end
        idle_inputs();
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL %s_timeout: no fill_done, want one", name);
        end else begin
            exp_fills++;
            if (dirty) exp_wbs++;
        end
        if (stall_pct == 0) begin
            checks++;
            if (done_cyc != (dirty ? 5 : 3)) begin
                errors++;
                $display("FAIL %s_latency: got %0d want %0d",
                         name, done_cyc, dirty ? 5 : 3);
            end
        end
        checks++;
        if (got0 !== l0 || got1 !== l1) begin
            errors++;
            $display("FAIL %s_fill: got %h/%h want %h/%h",
                     name, got0, got1, l0, l1);
        end
        checks++;
        if (rq.size() != 2 || rq[0] !== w0 || rq[1] !== w1) begin
            errors++;
            $display("FAIL %s_reads: got %0d reads first %h want 2 at %h",
                     name, rq.size(), rq.size() > 0 ? rq[0] : '0, w0);
        end
        checks++;
        if (wq_a.size() != nwb) begin
            errors++;
            $display("FAIL %s_wb_count: got %0d want %0d",
                     name, wq_a.size(), nwb);
        end else if (dirty && (wq_a[0] !== blk(va) || wq_d[0] !== v0 ||
                     wq_a[1] !== {va[AW-1:3], 3'b100} || wq_d[1] !== v1)) begin
            errors++;
            $display("FAIL %s_wb_data: got %h=%h %h=%h want %h=%h +4=%h",
                     name, wq_a[0], wq_d[0], wq_a[1], wq_d[1],
                     blk(va), v0, v1);
        end
        checks++;
        if (ctr != 1 || bad_tr) begin
            errors++;
            $display("FAIL %s_cctrans: got %0d cycles bad=%0d want 1 bad=0",
                     name, ctr, bad_tr);
        end
        checks++;
        if (bad_both || bad_order) begin
            errors++;
            $display("FAIL %s_bus: both=%0d order=%0d want 0/0",
                     name, bad_both, bad_order);
        end
    endtask

    task automatic do_snoop(input logic [AW-1:0] sa, input logic inv,
                            input int stall_pct, input bit abort,
                            input string name);
        logic [DW-1:0] words[$];
        logic hit, m, exp_inv, exp_dn, exp_v, exp_m;
        int target, ntr, ninv, ndn, post;
        bit resp_seen, bad_addr, bad_wr, bad_bus, pend_inv, pend_dn;
        hit = tag_valid && (blk(sa) == tag_addr);
        m = hit && tag_mod;
        target = m ? (abort ? 1 : 2) : 0;
        exp_inv = inv && hit;
        exp_dn = !inv && m;
        exp_v = tag_valid && !exp_inv;
        exp_m = tag_mod && !exp_dn;
        ntr = 0; ninv = 0; ndn = 0; post = 0;
        resp_seen = 0; bad_addr = 0; bad_wr = 0; bad_bus = 0;
        pend_inv = 0; pend_dn = 0;
        tick();
        ccwait = 1; ccsnoopaddr = sa; ccinv = inv; dwait = 0;
        for (int c = 0; c < 100 && post < 3; c++) begin
            if (c > 0) begin
                tick();
                if (pend_inv) tag_valid = 0;
                if (pend_dn) tag_mod = 0;
                pend_inv = 0; pend_dn = 0;
                dwait = ($urandom_range(99) < stall_pct);
            end
            #1;
            if (!ccwait) post++;
            if (cctrans) begin
                ntr++;
                if (snp_addr !== blk(sa)) bad_addr = 1;
                if (ccwrite !== m) bad_wr = 1;
                if (resp_seen && !dwait) words.push_back(dstore);
                resp_seen = 1;
            end
            if (dREN || dWEN) bad_bus = 1;
            if (snp_inval) begin ninv++; pend_inv = 1; end
            if (snp_dngrd) begin ndn++; pend_dn = 1; end
            if (ccwait && resp_seen && words.size() == target) ccwait = 0;
        end
        checks++;
        if (post < 3) begin
            errors++;
            $display("FAIL %s_timeout: response words %0d want %0d",
                     name, words.size(), target);
        end
        tick();
        if (pend_inv) tag_valid = 0;
        if (pend_dn) tag_mod = 0;
        idle_inputs();
        if (hit) exp_snphits++;
        if (stall_pct == 0) begin
            checks++;
            if (ntr != 1 + target) begin
                errors++;
                $display("FAIL %s_cctrans: got %0d cycles want %0d",
                         name, ntr, 1 + target);
            end
        end
        checks++;
        if (words.size() != target ||
            (target > 0 && words[0] !== tag_d0) ||
            (target > 1 && words[1] !== tag_d1)) begin
            errors++;
            $display("FAIL %s_supply: got %0d words first %h want %0d from %h",
                     name, words.size(), words.size() > 0 ? words[0] : '0,
                     target, tag_d0);
        end
        checks++;
        if (ninv != int'(exp_inv) || ndn != int'(exp_dn)) begin
            errors++;
            $display("FAIL %s_pulses: inval=%0d dngrd=%0d want %0d/%0d",
                     name, ninv, ndn, exp_inv, exp_dn);
        end
        checks++;
        if (bad_addr || bad_wr || bad_bus) begin
            errors++;
            $display("FAIL %s_resp: addr=%0d wr=%0d bus=%0d want 0/0/0",
                     name, bad_addr, bad_wr, bad_bus);
        end
        checks++;
        if (tag_valid !== exp_v || tag_mod !== exp_m) begin
            errors++;
            $display("FAIL %s_tag: v=%0d m=%0d want %0d/%0d",
                     name, tag_valid, tag_mod, exp_v, exp_m);
        end
    endtask

    task automatic set_tag(input logic [AW-1:0] a, input logic v,
                           input logic md, input logic [DW-1:0] d0,
                           input logic [DW-1:0] d1);
        tag_addr = blk(a); tag_valid = v; tag_mod = md;
        tag_d0 = d0; tag_d1 = d1;
    endtask

    task automatic test_clean_miss;
        do_miss(32'h100, 0, 0, '0, '0, '0, 32'hA, 32'hB, 0, "clean");
    endtask

    task automatic test_dirty_miss;
        do_miss(32'h40C, 1, 1, 32'h200, 32'h11, 32'h22,
                32'h5555, 32'h6666, 0, "dirty");
    endtask

    task automatic test_snoop_m;
        set_tag(32'h100, 1, 1, 32'hD0, 32'hD1);
        do_snoop(32'h104, 1, 0, 0, "snp_m_inv");
        set_tag(32'h100, 1, 1, 32'hD0, 32'hD1);
        do_snoop(32'h104, 0, 0, 0, "snp_m_dngrd");
        set_tag(32'h100, 1, 1, 32'hD0, 32'hD1);
        do_snoop(32'h300, 1, 0, 0, "snp_miss");
        set_tag(32'h100, 1, 0, 32'hD0, 32'hD1);
        do_snoop(32'h100, 1, 0, 0, "snp_s_inv");
        set_tag(32'h880, 1, 1, 32'hE0, 32'hE1);
        do_snoop(32'h884, 1, 0, 1, "snp_abort");
    endtask

    task automatic test_snoop_in_req;
        logic [AW-1:0] a;
        a = 32'h1238;
        set_tag(32'h500, 1, 0, '0, '0);
        ld0 = 32'hCAFE0000; ld1 = 32'hCAFE0004;
        tick();
        miss_req = 1; miss_addr = a; miss_excl = 1; dwait = 0;
        tick(); #1;
        checks++;
        if (cctrans !== 1 || ccwrite !== 1 || dREN !== 1) begin
            errors++;
            $display("FAIL req_first: trans=%0d wr=%0d ren=%0d want 1/1/1",
                     cctrans, ccwrite, dREN);
        end
        ccwait = 1; ccsnoopaddr = 32'h700; ccinv = 1;
        #1;
        checks++;
        if (cctrans !== 0 || dREN !== 0) begin
            errors++;
            $display("FAIL req_drop: trans=%0d ren=%0d want 0/0",
                     cctrans, dREN);
        end
        tick(); #1;
        checks++;
        if (cctrans !== 1 || ccwrite !== 0 || dREN !== 0 ||
            snp_addr !== 32'h700) begin
            errors++;
            $display("FAIL req_snp: trans=%0d wr=%0d ren=%0d sa=%h want 1/0/0/700",
                     cctrans, ccwrite, dREN, snp_addr);
        end
        ccwait = 0;
        tick(); #1;
        checks++;
        if (snp_inval !== 0 || snp_dngrd !== 0 || cctrans !== 0) begin
            errors++;
            $display("FAIL req_sfin: inv=%0d dn=%0d trans=%0d want 0/0/0",
                     snp_inval, snp_dngrd, cctrans);
        end
        tick(); #1;
        checks++;
        if (cctrans !== 1 || ccwrite !== 1 || dREN !== 1 ||
            daddr !== 32'h1238) begin
            errors++;
            $display("FAIL req_retry: trans=%0d wr=%0d ren=%0d a=%h want 1/1/1/1238",
                     cctrans, ccwrite, dREN, daddr);
        end
        tick(); tick(); #1;
        checks++;
        if (fill_done !== 1 || fill_data0 !== 32'hCAFE0000 ||
            fill_data1 !== 32'hCAFE0004) begin
            errors++;
            $display("FAIL req_fill: done=%0d %h/%h want 1 CAFE0000/CAFE0004",
                     fill_done, fill_data0, fill_data1);
        end else begin
            exp_fills++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_rd1;
        int nfill;
        ld0 = 32'h77; ld1 = 32'h88;
        tick();
        miss_req = 1; miss_addr = 32'h2000; dwait = 0;
        tick(); tick(); #1;
        checks++;
        if (dREN !== 1 || daddr !== 32'h2004) begin
            errors++;
            $display("FAIL rst_rd1_pre: ren=%0d a=%h want 1/2004", dREN, daddr);
        end
        RST = 1; miss_req = 0;
        tick();
        RST = 0;
        exp_fills = 0; exp_wbs = 0; exp_snphits = 0;
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL rst_rd1_outs: outs=%h want 0", all_outs);
        end
        nfill = 0;
        for (int c = 0; c < 4; c++) begin
            tick(); #1;
            if (fill_done) nfill++;
        end
        checks++;
        if (nfill != 0) begin
            errors++;
            $display("FAIL rst_rd1_nofill: got %0d fills want 0", nfill);
        end
        idle_inputs();
    endtask

    task automatic test_random;
        logic [AW-1:0] a;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(1) == 1) begin
                do_miss($urandom, 1'($urandom_range(1)), 1'($urandom_range(1)),
                        $urandom, $urandom, $urandom, $urandom, $urandom,
                        30, "rnd_miss");
            end else begin
                set_tag($urandom, 1'($urandom_range(1)),
                        1'($urandom_range(1)), $urandom, $urandom);
                if ($urandom_range(2) != 0)
                    a = tag_addr | AW'($urandom_range(7));
                else
                    a = $urandom;
                do_snoop(a, 1'($urandom_range(1)), 30,
                         bit'($urandom_range(1)), "rnd_snp");
            end
        end
    endtask

`ifdef DCACHE_AGENT_STATS_EN
    task automatic test_stats;
        #1;
        checks++;
        if (stat_fills !== CW'(exp_fills) || stat_wbs !== CW'(exp_wbs) ||
            stat_snphits !== CW'(exp_snphits)) begin
            errors++;
            $display("FAIL stats: got %0d/%0d/%0d want %0d/%0d/%0d",
                     stat_fills, stat_wbs, stat_snphits,
                     exp_fills, exp_wbs, exp_snphits);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_snoop_m();
        test_snoop_in_req();
        test_reset_in_rd1();
        test_random();
`ifdef DCACHE_AGENT_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
